neuron_dot_sequencer: RTL and testbench
=======================================

// Module: neuron_dot_sequencer
// PURPOSE
//  Sequences the shared network BRAM and one fixed-point multiply-accumulate datapath.
//  Computes a single neuron pre-activation: sum(act[i]*wgt[i]) for i in 0..count-1.
//  Launched by the top-level training FSM during forward propagation via a start/done handshake.
//  Read-only BRAM master: drives ena and addr, consumes data one cycle later.
// PARAMETERS
//  ADDR_W  5   BRAM address width
//  DATA_W  16  signed operand/result width (two's complement, Q(DATA_W-FRAC_W).FRAC_W)
//  FRAC_W  8   fractional bits
//  ACC_W   40  accumulator width; must be >= 2*DATA_W
//  CNT_W   4   width of term-count input
// PORTS
//  clk_i          in   1       clock, rising edge
//  reset_i        in   1       asynchronous, active-high reset
//  start_i        in   1       launch request; sampled only in IDLE
//  act_base_i     in   ADDR_W  BRAM address of act[0]; sampled with start
//  wgt_base_i     in   ADDR_W  BRAM address of wgt[0]; sampled with start
//  count_i        in   CNT_W   number of terms N; sampled with start
//  mem_ena_o      out  1       BRAM enable (read strobe)
//  mem_addr_o     out  ADDR_W  BRAM address
//  mem_rd_data_i  in   DATA_W  BRAM read data, valid 1 cycle after ena
//  busy_o         out  1       high from cycle after start until done cycle inclusive
//  done_o         out  1       single-cycle pulse; result_o/overflow_o valid on that cycle
//  result_o       out  DATA_W  neuron output, held until next done
//  overflow_o     out  1       result saturated, held with result_o
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE; accumulator, index and captured act cleared.
//  FSM states: IDLE, RD_ACT, RD_WGT, MAC, FINISH (typedef in shared package).
//  IDLE:   start_i=1 -> latch bases/count, acc<=0, idx<=0.
//          Then go to RD_ACT, or to FINISH if count_i==0.
//  RD_ACT: mem_ena_o=1, mem_addr_o=act_base+idx -> RD_WGT.
//  RD_WGT: mem_ena_o=1, mem_addr_o=wgt_base+idx, capture act<=mem_rd_data_i -> MAC.
//  MAC:    acc <= acc + sext(act*mem_rd_data_i).
//          If idx==N-1 -> FINISH; else idx++ -> RD_ACT.
//  FINISH: done_o=1, result_o/overflow_o registered, busy_o=1 -> IDLE.
//  mem_ena_o is 0 in IDLE/MAC/FINISH. mem_addr_o is don't-care there and driven to 0.
//  Latency: start cycle t -> done_o at t+3N+1; N=0 -> done at t+1 with result 0.
//  Address arithmetic is modulo 2^ADDR_W; wrap-around is legal and silent.
//  Product is a full 2*DATA_W signed value, sign-extended into ACC_W; no intermediate saturation.
//  Result = acc >>> FRAC_W (arithmetic, floor rounding).
//  The result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; overflow_o=1 iff saturation occurred.
//  start_i while busy: ignored; no queueing.
//  start_i in the FINISH cycle: ignored; may be reissued the next cycle (IDLE).
//  Back-to-back operation: start asserted in the cycle after done is accepted.
//  Reset mid-operation: immediate return to IDLE, ena drops, no done pulse, result_o cleared.
//  Inputs act_base_i/wgt_base_i/count_i may change freely after the start cycle.
// CONFIGURATION
//  NEURON_RELU_EN defined:
//    After saturation, a negative result is forced to 0 (ReLU).
//    overflow_o still reflects saturation before the clamp.
//  NEURON_RELU_EN undefined: result_o is the signed saturated linear value.
//  Latency is identical in both builds.
// STRUCTURE
//  Shared package nn_pkg: seq_state_t enum and the Q-format constants.
//    Constants: FRAC_W default, Q_ONE = 1<<FRAC_W, Q_MAX, Q_MIN.
//  Sub-module fixed_mac:
//    Registered signed multiply-accumulate with clear, plus output scaling and saturation.
//    Controls: acc_clr, acc_en. Outputs: sat_result, sat_flag.
//  The sequencer holds the FSM, index counter, address generation and handshake.
// TESTING
//  Use a BRAM model with 1-cycle read latency; Q8.8 unless noted.
//  1. N=1, act=0x0200 (2.0), wgt=0x0100 (1.0)
//     -> done at t+4, result_o=0x0200, overflow_o=0.
//  2. N=3, act={0x0100,0x0200,0xFF80}, wgt={0x0080,0x0040,0x0200}
//     -> result_o=0x0000 (0.5+0.5-1.0), done at t+10.
//  3. N=4, all act=wgt=0x7FFF -> result_o=0x7FFF, overflow_o=1.
//     Also all act=0x8000, wgt=0x7FFF -> result_o=0x8000, overflow_o=1.
//  4. N=1, act=0x0100, wgt=0xFF00
//     -> 0xFF00 without NEURON_RELU_EN; 0x0000 with it. overflow_o=0 in both.
//  5. act_base=30, N=4 -> reads at addresses 30,31,0,1 (wrap).
//     N=0 -> done at t+1, result_o=0.
//  6. Assert reset_i mid-run (in RD_WGT of term 2)
//     -> next cycle: ena=0, busy=0, no done. A fresh start after reset then gives correct results.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared neural-network definitions: Q-format constants and the dot-product sequencer states.
package nn_pkg;

  localparam int Q_DATA_W = 16;
  localparam int Q_FRAC_W = 8;
  localparam logic signed [Q_DATA_W-1:0] Q_ONE = 16'sh0100;
  localparam logic signed [Q_DATA_W-1:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [Q_DATA_W-1:0] Q_MIN = 16'sh8000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_ACT = 3'd1;
  localparam logic [2:0] ST_RD_WGT = 3'd2;
  localparam logic [2:0] ST_MAC    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_RD_ACT = ST_RD_ACT,
    S_RD_WGT = ST_RD_WGT,
    S_MAC    = ST_MAC,
    S_FINISH = ST_FINISH
  } seq_state_t;

endpackage

// File: rtl/fixed_mac.sv
// Signed fixed-point multiply-accumulate with clear. Scaling and saturation are taken from the
// accumulator's next value so the owner can register the result in the same cycle as the last MAC.
module fixed_mac import nn_pkg::*; #(
  parameter int DATA_W = Q_DATA_W,
  parameter int FRAC_W = Q_FRAC_W,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_clr,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sat_result,
  output logic              sat_flag
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_r;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [ACC_W-1:0]    scaled;
  logic [ACC_W-DATA_W:0]      top_bits;

  // Full-precision product and next accumulator value
  always_comb begin
    prod = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
    if (acc_clr) begin
      acc_next = {ACC_W{1'b0}};
    end else if (acc_en) begin
      acc_next = acc_r + ACC_W'(prod);
    end else begin
      acc_next = acc_r;
    end
  end

  // Floor-scale back to Q format; the value fits only if all bits above the sign bit agree
  always_comb begin
    scaled   = acc_next >>> FRAC_W;
    top_bits = scaled[ACC_W-1:DATA_W-1];
    sat_flag = !((&top_bits) || !(|top_bits));
    if (!sat_flag) begin
      sat_result = scaled[DATA_W-1:0];
    end else if (scaled[ACC_W-1]) begin
      sat_result = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_result = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // Accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {ACC_W{1'b0}};
    end else begin
      acc_r <= acc_next;
    end
  end

endmodule

// File: rtl/neuron_dot_sequencer.sv
// Single-neuron dot-product sequencer: drives BRAM reads and the fixed_mac datapath.
// Optional build macro NEURON_RELU_EN clamps negative results to zero.
module neuron_dot_sequencer import nn_pkg::*; #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = Q_DATA_W,
  parameter int FRAC_W = Q_FRAC_W,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] act_base_i,
  input  logic [ADDR_W-1:0] wgt_base_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              mem_ena_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              overflow_o
);

  seq_state_t        state_r, state_next;
  logic [CNT_W-1:0]  idx_r, idx_next;
  logic [CNT_W-1:0]  count_r, count_next;
  logic [ADDR_W-1:0] act_base_r, act_base_next;
  logic [ADDR_W-1:0] wgt_base_r, wgt_base_next;
  logic [DATA_W-1:0] act_r;
  logic              acc_clr, acc_en;
  logic              ena_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] sat_result, final_result;
  logic              sat_flag;

  fixed_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk        (clk_i),
    .rst        (reset_i),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .a          (act_r),
    .b          (mem_rd_data_i),
    .sat_result (sat_result),
    .sat_flag   (sat_flag)
  );

  // Next-state, index and operand-latch logic
  always_comb begin
    state_next    = state_r;
    idx_next      = idx_r;
    count_next    = count_r;
    act_base_next = act_base_r;
    wgt_base_next = wgt_base_r;
    acc_clr       = 1'b0;
    acc_en        = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          act_base_next = act_base_i;
          wgt_base_next = wgt_base_i;
          count_next    = count_i;
          idx_next      = {CNT_W{1'b0}};
          acc_clr       = 1'b1;
          state_next    = (count_i == {CNT_W{1'b0}}) ? S_FINISH : S_RD_ACT;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RD_ACT: state_next = S_RD_WGT;
      S_RD_WGT: state_next = S_MAC;
      S_MAC: begin
        acc_en = 1'b1;
        if (idx_r == (count_r - CNT_W'(1))) begin
          state_next = S_FINISH;
        end else begin
          idx_next   = idx_r + CNT_W'(1);
          state_next = S_RD_ACT;
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Read strobe and address for the coming cycle, so the BRAM port comes straight from flops
  always_comb begin
    case (state_next)
      S_RD_ACT: begin
        ena_next  = 1'b1;
        addr_next = act_base_next + ADDR_W'(idx_next);
      end
      S_RD_WGT: begin
        ena_next  = 1'b1;
        addr_next = wgt_base_next + ADDR_W'(idx_next);
      end
      default: begin
        ena_next  = 1'b0;
        addr_next = {ADDR_W{1'b0}};
      end
    endcase
  end

`ifdef NEURON_RELU_EN
  // ReLU after saturation; the overflow flag still reports the pre-clamp saturation
  always_comb begin
    if (sat_result[DATA_W-1]) begin
      final_result = {DATA_W{1'b0}};
    end else begin
      final_result = sat_result;
    end
  end
`else
  // Linear build passes the saturated value through
  always_comb begin
    final_result = sat_result;
  end
`endif

  // Sequencer state and registered outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= S_IDLE;
      idx_r      <= {CNT_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      act_base_r <= {ADDR_W{1'b0}};
      wgt_base_r <= {ADDR_W{1'b0}};
      act_r      <= {DATA_W{1'b0}};
      mem_ena_o  <= 1'b0;
      mem_addr_o <= {ADDR_W{1'b0}};
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= {DATA_W{1'b0}};
      overflow_o <= 1'b0;
    end else begin
      state_r    <= state_next;
      idx_r      <= idx_next;
      count_r    <= count_next;
      act_base_r <= act_base_next;
      wgt_base_r <= wgt_base_next;
      if (state_r == S_RD_WGT) begin
        act_r <= mem_rd_data_i;
      end
      mem_ena_o  <= ena_next;
      mem_addr_o <= addr_next;
      busy_o     <= (state_next != S_IDLE);
      done_o     <= (state_next == S_FINISH);
      if (state_next == S_FINISH) begin
        result_o   <= final_result;
        overflow_o <= sat_flag;
      end
    end
  end

endmodule

// File: tb/tb_neuron_dot_sequencer.sv
// Directed bench for neuron_dot_sequencer with a 1-cycle-latency BRAM model (Q8.8).
module tb_neuron_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  act_base, wgt_base;
  logic [3:0]  count;
  logic        mem_ena;
  logic [4:0]  mem_addr;
  logic [15:0] rd_data = 16'h0000;
  logic        busy, done, ovf;
  logic [15:0] result;
  logic [15:0] mem [0:31];
  logic [4:0]  alog [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  neuron_dot_sequencer dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .start_i       (start),
    .act_base_i    (act_base),
    .wgt_base_i    (wgt_base),
    .count_i       (count),
    .mem_ena_o     (mem_ena),
    .mem_addr_o    (mem_addr),
    .mem_rd_data_i (rd_data),
    .busy_o        (busy),
    .done_o        (done),
    .result_o      (result),
    .overflow_o    (ovf)
  );

  always @(posedge clk) begin
    if (mem_ena) begin
      rd_data <= mem[mem_addr];
      alog.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; leaves at the negedge of the IDLE cycle following done
  task automatic run(input string tag, input logic [4:0] ab, input logic [4:0] wb,
                     input logic [3:0] n, input logic [15:0] er, input logic eo,
                     input int elat, input bit poke_busy, input bit poke_finish);
    int lat;
    start = 1'b1; act_base = ab; wgt_base = wb; count = n;
    alog.delete();
    @(negedge clk);
    start = 1'b0;
    act_base = 5'($urandom); wgt_base = 5'($urandom); count = 4'($urandom);
    lat = 1;
    while (!done && lat < 100) begin
      start = (poke_busy && lat == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".result"}, 32'(result), 32'(er));
    chk({tag, ".overflow"}, 32'(ovf), 32'(eo));
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd1);
    if (poke_finish) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".done_drop"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".held"}, 32'(result), 32'(er));
  endtask

  initial begin
    logic [4:0]  wrap_exp [8];
    logic [15:0] relu_exp;
    wrap_exp = '{5'd30, 5'd26, 5'd31, 5'd27, 5'd0, 5'd28, 5'd1, 5'd29};
`ifdef NEURON_RELU_EN
    relu_exp = 16'h0000;
`else
    relu_exp = 16'hFF00;
`endif
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h0200; mem[16] = 16'h0100;
    mem[1]  = 16'h0100; mem[2]  = 16'h0200; mem[3]  = 16'hFF80;
    mem[17] = 16'h0080; mem[18] = 16'h0040; mem[19] = 16'h0200;
    for (int i = 4; i < 8; i++)  mem[i] = 16'h7FFF;
    for (int i = 8; i < 12; i++) mem[i] = 16'h8000;
    for (int i = 20; i < 24; i++) mem[i] = 16'h7FFF;
    mem[12] = 16'h0100; mem[24] = 16'hFF00;
    mem[30] = 16'h0100; mem[31] = 16'h0100;
    for (int i = 26; i < 30; i++) mem[i] = 16'h0100;

    rst = 1'b1; start = 1'b0; act_base = 5'd0; wgt_base = 5'd0; count = 4'd0;
    @(negedge clk); @(negedge clk);
    chk("reset.ena", 32'(mem_ena), 32'd0);
    chk("reset.addr", 32'(mem_addr), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.result", 32'(result), 32'd0);
    chk("reset.ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("t1", 5'd0, 5'd16, 4'd1, 16'h0200, 1'b0, 4, 1'b0, 1'b0);
    chk("t1.nreads", 32'(alog.size()), 32'd2);
    if (alog.size() == 2) begin
      chk("t1.addr0", 32'(alog[0]), 32'd0);
      chk("t1.addr1", 32'(alog[1]), 32'd16);
    end
    run("t2", 5'd1, 5'd17, 4'd3, 16'h0000, 1'b0, 10, 1'b1, 1'b0);
    run("t3pos", 5'd4, 5'd20, 4'd4, 16'h7FFF, 1'b1, 13, 1'b0, 1'b0);
    run("t3neg", 5'd8, 5'd20, 4'd4, 16'h8000, 1'b1, 13, 1'b0, 1'b1);
    run("t4", 5'd12, 5'd24, 4'd1, relu_exp, 1'b0, 4, 1'b0, 1'b0);
    run("t5wrap", 5'd30, 5'd26, 4'd4, 16'h0500, 1'b0, 13, 1'b0, 1'b0);
    chk("t5.nreads", 32'(alog.size()), 32'd8);
    if (alog.size() == 8) begin
      for (int i = 0; i < 8; i++) chk($sformatf("t5.addr%0d", i), 32'(alog[i]), 32'(wrap_exp[i]));
    end
    run("t5zero", 5'd3, 5'd9, 4'd0, 16'h0000, 1'b0, 1, 1'b0, 1'b0);

    // Reset while reading the second weight
    run("t6pre", 5'd0, 5'd16, 4'd1, 16'h0200, 1'b0, 4, 1'b0, 1'b0);
    start = 1'b1; act_base = 5'd1; wgt_base = 5'd17; count = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6.in_rdwgt_ena", 32'(mem_ena), 32'd1);
    chk("t6.in_rdwgt_addr", 32'(mem_addr), 32'd18);
    rst = 1'b1;
    @(negedge clk);
    chk("t6.ena", 32'(mem_ena), 32'd0);
    chk("t6.busy", 32'(busy), 32'd0);
    chk("t6.done", 32'(done), 32'd0);
    chk("t6.result", 32'(result), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6.no_done", 32'(done), 32'd0);
    chk("t6.still_idle", 32'(busy), 32'd0);
    run("t6post", 5'd0, 5'd16, 4'd1, 16'h0200, 1'b0, 4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
